mem_responder: RTL

Byte-wide memory and I/O responder on the far side of the CPU memory bus. It answers the memory controller's address, write-strobe and data-out signals with registered read data one cycle later. It owns the 256 KiB RAM and the memory-mapped UART transmit path, and it drives `io_buffer_full` back to the controller. It sits between the CPU top-level memory pins and the board RAM/UART in both simulation and FPGA builds.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 11 +
 rtl/mem_responder_txfifo.sv | 70 +++++++
 rtl/mem_responder.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory/I-O responder: I/O region decode and port addresses.
package mem_responder_pkg;

  localparam logic [31:0] IO_BASE   = 32'h0003_0000;
  localparam logic [31:0] UART_PORT = 32'h0003_0000;
  localparam logic [31:0] HALT_PORT = 32'h0003_0004;
  localparam logic [31:0] IO_MASK   = 32'h0003_0000;

  // Only bits [17:16] select the I/O region; upper address bits do not participate.
  function automatic logic is_io_addr(input logic [31:0] addr);
    return (addr & IO_MASK) == IO_BASE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus between the memory controller (master) and the responder (slave).
interface mem_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_wr, mem_dout, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_responder_txfifo.sv
// UART transmit FIFO: circular buffer with occupancy count, sticky overflow and a
// registered almost-full flag raised at DEPTH-2 entries.
module mem_responder_txfifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push_i,
  input  logic [7:0]               push_dat_i,
  input  logic                     pop_rdy_i,
  output logic [7:0]               head_dat_o,
  output logic                     head_vld_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          afull_q, afull_d;
  logic          pop, full, push_ok;

  assign head_vld_o = (count_q != '0);
  assign pop        = head_vld_o && pop_rdy_i;
  assign full       = (count_q == CW'(DEPTH));
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_i && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q || (push_i && !push_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    afull_d  = (count_d >= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o    = head_vld_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o       = count_q;
  assign almost_full_o = afull_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/mem_responder.sv
// Byte-wide RAM and memory-mapped UART/halt responder with one-cycle registered reads.
// MEM_RESPONDER_IO_EN enables the I/O region, TX FIFO, sim_done and io_buffer_full.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int TX_DEPTH   = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  mem_responder_if.slave   bus,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  output logic             tx_overflow,
  output logic             sim_done
);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_rd_q;
  logic                  src_ram_q;
  logic [7:0]            io_rd_q, io_rd_d;
  logic                  is_io, ram_we, ram_re;

  assign ram_addr = bus.mem_a[ADDR_WIDTH-1:0];
  assign ram_we   = bus.mem_wr && !is_io;
  assign ram_re   = !bus.mem_wr && !is_io;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= bus.mem_dout;
    if (ram_re) ram_rd_q <= ram[ram_addr];
  end

  // RAM data comes straight from the array register; everything else (writes, I/O) from io_rd_q.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      src_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
    end else begin
      src_ram_q <= ram_re;
      io_rd_q   <= io_rd_d;
    end
  end

  assign bus.mem_din = src_ram_q ? ram_rd_q : io_rd_q;

`ifdef MEM_RESPONDER_IO_EN
  logic [$clog2(TX_DEPTH):0] fifo_count;
  logic                      fifo_afull;
  logic                      uart_hit, halt_hit;
  logic                      sim_done_q;

  assign is_io    = is_io_addr(bus.mem_a);
  assign uart_hit = is_io && (bus.mem_a == UART_PORT);
  assign halt_hit = is_io && (bus.mem_a == HALT_PORT);

  mem_responder_txfifo #(.DEPTH(TX_DEPTH)) u_txfifo (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .push_i        (uart_hit && bus.mem_wr),
    .push_dat_i    (bus.mem_dout),
    .pop_rdy_i     (uart_tx_ready),
    .head_dat_o    (uart_tx_data),
    .head_vld_o    (uart_tx_valid),
    .count_o       (fifo_count),
    .almost_full_o (fifo_afull),
    .overflow_o    (tx_overflow)
  );

  always_comb begin
    io_rd_d = 8'h00;
    if (halt_hit && !bus.mem_wr) io_rd_d = 8'(fifo_count);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) sim_done_q <= 1'b0;
    else           sim_done_q <= halt_hit && bus.mem_wr;
  end

  assign sim_done           = sim_done_q;
  assign bus.io_buffer_full = fifo_afull;
`else
  logic unused_ok;

  assign is_io              = 1'b0;
  assign io_rd_d            = 8'h00;
  assign uart_tx_data       = 8'h00;
  assign uart_tx_valid      = 1'b0;
  assign tx_overflow        = 1'b0;
  assign sim_done           = 1'b0;
  assign bus.io_buffer_full = 1'b0;
  assign unused_ok          = ^{bus.mem_a[31:ADDR_WIDTH], uart_tx_ready, TX_DEPTH[0]};
`endif

endmodule
